// File: rtl/bcd_convert_sched_pkg.sv
// Shared types and constants for the stopwatch binary-to-BCD conversion scheduler.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int BCD_MAX         = 9999;
  localparam int BCD_CORR_THRESH = 5;
  localparam int BCD_CORR_ADD    = 3;

endpackage

// File: rtl/bcd_convert_sched_if.sv
// Request/grant and result bundle between the two requesters, the scheduler and the display driver.
interface bcd_convert_sched_if #(
  parameter int WIDTH = 16
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] val0;
  logic [WIDTH-1:0] val1;
  logic             ack0;
  logic             ack1;
  logic             busy;
  logic             done;
  logic             owner;
  logic             overflow;
  logic [3:0]       digit1;
  logic [3:0]       digit2;
  logic [3:0]       digit3;
  logic [3:0]       digit4;

  modport master (
    output req0, req1, val0, val1,
    input  ack0, ack1, busy, done, owner, overflow,
    input  digit1, digit2, digit3, digit4
  );

  modport slave (
    input  req0, req1, val0, val1,
    output ack0, ack1, busy, done, owner, overflow,
    output digit1, digit2, digit3, digit4
  );
endinterface

// File: rtl/bcd_convert_sched_dabble_step.sv
// One double-dabble iteration: add-3 correction on every digit >= 5, then shift in one binary bit.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic [4*NDIG-1:0] acc_i,
  input  logic              bit_i,
  output logic [4*NDIG-1:0] acc_o
);

  logic [4*NDIG-1:0] corr;

  always_comb begin
    corr = acc_i;
    for (int d = 0; d < NDIG; d++) begin
      if (acc_i[4*d +: 4] >= 4'(BCD_CORR_THRESH)) begin
        corr[4*d +: 4] = acc_i[4*d +: 4] + 4'(BCD_CORR_ADD);
      end
    end
  end

  assign acc_o = {corr[4*NDIG-2:0], bit_i};

endmodule

// File: rtl/bcd_convert_sched.sv
// Round-robin scheduler feeding a bit-serial shift-and-add-3 converter; results are held
// in output registers for the 7-segment driver.
module bcd_convert_sched
  import bcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NDIG  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_convert_sched_if.slave bus
);

  localparam int CW   = $clog2(WIDTH);
  localparam int ACCW = 4 * NDIG;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic              ovfPend_q, ovfPend_d;
  logic [ACCW-1:0]   dig_q, dig_d;
  logic              ovf_q, ovf_d;
  logic              owner_q, owner_d;

  logic [ACCW-1:0]   stepAcc;
  logic [WIDTH-1:0]  capVal;

  bcd_dabble_step #(.NDIG(NDIG)) u_step (
    .acc_i (acc_q),
    .bit_i (shreg_q[WIDTH-1]),
    .acc_o (stepAcc)
  );

  assign capVal = grant_q ? bus.val1 : bus.val0;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    ovfPend_d = ovfPend_q;
    dig_d     = dig_q;
    ovf_d     = ovf_q;
    owner_d   = owner_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester not served last wins; otherwise whoever is asking.
          grant_d = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          last_d  = grant_d;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shreg_d   = capVal;
        acc_d     = '0;
        cnt_d     = '0;
        ovfPend_d = int'(capVal) > BCD_MAX;
        state_d   = SHIFT;
      end
      SHIFT: begin
        acc_d   = stepAcc;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          dig_d   = ovfPend_q ? {NDIG{4'd9}} : stepAcc;
          ovf_d   = ovfPend_q;
          owner_d = grant_q;
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      shreg_q   <= '0;
      acc_q     <= '0;
      ovfPend_q <= 1'b0;
      dig_q     <= '0;
      ovf_q     <= 1'b0;
      owner_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      acc_q     <= acc_d;
      ovfPend_q <= ovfPend_d;
      dig_q     <= dig_d;
      ovf_q     <= ovf_d;
      owner_q   <= owner_d;
    end
  end

  assign bus.ack0     = (state_q == LOAD) && !grant_q;
  assign bus.ack1     = (state_q == LOAD) && grant_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == FINISH);
  assign bus.owner    = owner_q;
  assign bus.overflow = ovf_q;
  assign bus.digit1   = dig_q[3:0];
  assign bus.digit2   = dig_q[7:4];
  assign bus.digit3   = dig_q[11:8];
  assign bus.digit4   = dig_q[15:12];

endmodule

// File: tb/tb_bcd_convert_sched.sv
// Self-checking bench for bcd_convert_sched: directed scenarios plus a randomized sweep
// against a decimal-arithmetic reference model.
module tb_bcd_convert_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   overlapSeen = 0;

  always #5 clk = ~clk;

  bcd_convert_sched_if #(.WIDTH(16)) bus ();

  bcd_convert_sched #(.WIDTH(16), .NDIG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: {overflow, thousands, hundreds, tens, ones}, saturating at 9999.
  function automatic logic [16:0] refConvert(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {(v > 9999), 4'(c / 1000 % 10), 4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10)};
  endfunction

  function automatic logic [15:0] digitsNow();
    return {bus.digit4, bus.digit3, bus.digit2, bus.digit1};
  endfunction

  function automatic logic [16:0] resultNow();
    return {bus.overflow, bus.digit4, bus.digit3, bus.digit2, bus.digit1};
  endfunction

  task automatic waitIdle();
    for (int i = 0; i < 60 && bus.busy; i++) @(negedge clk);
    @(negedge clk);
  endtask

  // Issue one request, drop it on ack, and report ack/done latency in edges after the IDLE cycle.
  task automatic runJob(input int r, input logic [15:0] v, output int ackLat, output int doneLat);
    ackLat  = -1;
    doneLat = -1;
    waitIdle();
    if (r == 0) begin bus.val0 = v; bus.req0 = 1'b1; end
    else        begin bus.val1 = v; bus.req1 = 1'b1; end
    for (int k = 1; k <= 40 && doneLat < 0; k++) begin
      @(posedge clk); #1;
      if ((bus.ack0 || bus.ack1) && bus.done) overlapSeen++;
      if ((bus.ack0 || bus.ack1) && ackLat < 0) begin
        ackLat = k;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      if (bus.done) doneLat = k;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ack0, bus.ack1, bus.busy, bus.done, bus.owner, bus.overflow} !== 6'b0)
      $display("[TB] FAIL reset_ctrl: got %b want 000000",
               {bus.ack0, bus.ack1, bus.busy, bus.done, bus.owner, bus.overflow});
    else passed++;
    checks++;
    if (digitsNow() !== 16'h0000) $display("[TB] FAIL reset_digits: got %h want 0000", digitsNow());
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int a, d;
    logic [16:0] exp;
    exp = refConvert(1234);
    runJob(0, 16'd1234, a, d);
    checks++;
    if (a !== 1) $display("[TB] FAIL single_ack_lat: got %0d want 1", a); else passed++;
    checks++;
    if (d !== 18) $display("[TB] FAIL single_done_lat: got %0d want 18", d); else passed++;
    checks++;
    if (resultNow() !== exp) $display("[TB] FAIL single_result: got %h want %h", resultNow(), exp);
    else passed++;
    checks++;
    if (bus.owner !== 1'b0) $display("[TB] FAIL single_owner: got %b want 0", bus.owner); else passed++;
  endtask

  task automatic test_boundary();
    int vals[5] = '{0, 9999, 10000, 65535, 1};
    int a, d;
    logic [16:0] exp;
    foreach (vals[i]) begin
      exp = refConvert(vals[i]);
      runJob(0, 16'(vals[i]), a, d);
      checks++;
      if (resultNow() !== exp)
        $display("[TB] FAIL boundary_%0d: got %h want %h", vals[i], resultNow(), exp);
      else passed++;
      checks++;
      if (a !== 1 || d !== 18)
        $display("[TB] FAIL boundary_lat_%0d: got ack %0d done %0d want 1/18", vals[i], a, d);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int doneT[$];
    int owners[$];
    logic [16:0] results[$];
    int lastGrant = 1;
    int expG;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.val0 = 16'd42;
    bus.val1 = 16'd907;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int k = 1; k <= 80 && doneT.size() < 3; k++) begin
      @(posedge clk); #1;
      if (bus.ack0) grants.push_back(0);
      if (bus.ack1) grants.push_back(1);
      if (bus.done) begin
        doneT.push_back(k);
        owners.push_back(int'(bus.owner));
        results.push_back(resultNow());
        if (doneT.size() == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    checks++;
    if (doneT.size() != 3 || grants.size() < 3)
      $display("[TB] FAIL rr_count: got %0d dones %0d grants want 3/3", doneT.size(), grants.size());
    else begin
      passed++;
      for (int i = 0; i < 3; i++) begin
        expG = (lastGrant == 1) ? 0 : 1;
        lastGrant = expG;
        checks++;
        if (grants[i] != expG || owners[i] != expG)
          $display("[TB] FAIL rr_grant_%0d: got grant %0d owner %0d want %0d", i, grants[i], owners[i], expG);
        else passed++;
        checks++;
        if (results[i] !== refConvert(expG == 0 ? 42 : 907))
          $display("[TB] FAIL rr_result_%0d: got %h want %h", i, results[i], refConvert(expG == 0 ? 42 : 907));
        else passed++;
        if (i > 0) begin
          checks++;
          if (doneT[i] - doneT[i-1] != 19)
            $display("[TB] FAIL rr_spacing_%0d: got %0d want 19", i, doneT[i] - doneT[i-1]);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_busy_request();
    int ack0T = -1, ack1T = -1, done1T = -1, done2T = -1;
    int heldBad = 0;
    logic [16:0] firstRes = '0, secondRes = '0;
    int secondOwner = -1;
    waitIdle();
    bus.val0 = 16'd1234;
    bus.req0 = 1'b1;
    for (int k = 1; k <= 60 && done2T < 0; k++) begin
      @(posedge clk); #1;
      if (k == 6) begin bus.val1 = 16'd321; bus.req1 = 1'b1; end
      if (bus.ack0 && ack0T < 0) begin ack0T = k; bus.req0 = 1'b0; end
      if (bus.ack1 && ack1T < 0) begin ack1T = k; bus.req1 = 1'b0; end
      if (done1T >= 0 && !bus.done && digitsNow() !== 16'h1234) heldBad++;
      if (bus.done) begin
        if (done1T < 0) begin done1T = k; firstRes = resultNow(); end
        else begin done2T = k; secondRes = resultNow(); secondOwner = int'(bus.owner); end
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    checks++;
    if (ack0T != 1 || done1T != 18)
      $display("[TB] FAIL busy_first_timing: got ack %0d done %0d want 1/18", ack0T, done1T);
    else passed++;
    checks++;
    if (firstRes !== refConvert(1234))
      $display("[TB] FAIL busy_first_result: got %h want %h", firstRes, refConvert(1234));
    else passed++;
    checks++;
    if (ack1T != 20) $display("[TB] FAIL busy_ack1_time: got %0d want 20", ack1T); else passed++;
    checks++;
    if (heldBad != 0) $display("[TB] FAIL busy_digits_held: got %0d changed cycles want 0", heldBad);
    else passed++;
    checks++;
    if (done2T != 37 || secondRes !== refConvert(321) || secondOwner != 1)
      $display("[TB] FAIL busy_second: got t=%0d res=%h owner=%0d want 37/%h/1",
               done2T, secondRes, secondOwner, refConvert(321));
    else passed++;
  endtask

  task automatic test_reset_mid();
    int a, d;
    logic wasBusy;
    waitIdle();
    bus.val0 = 16'd777;
    bus.req0 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (bus.ack0) bus.req0 = 1'b0;
    end
    bus.req0 = 1'b0;
    wasBusy = bus.busy;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wasBusy !== 1'b1) $display("[TB] FAIL midreset_busy_before: got %b want 1", wasBusy); else passed++;
    checks++;
    if ({bus.ack0, bus.ack1, bus.busy, bus.done, bus.owner, bus.overflow, digitsNow()} !== 22'b0)
      $display("[TB] FAIL midreset_outputs: got %h want 0",
               {bus.ack0, bus.ack1, bus.busy, bus.done, bus.owner, bus.overflow, digitsNow()});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    runJob(0, 16'd5, a, d);
    checks++;
    if (a !== 1 || d !== 18 || resultNow() !== refConvert(5) || bus.owner !== 1'b0)
      $display("[TB] FAIL midreset_recover: got ack %0d done %0d res %h owner %b want 1/18/%h/0",
               a, d, resultNow(), bus.owner, refConvert(5));
    else passed++;
  endtask

  task automatic test_random();
    int a, d, r, mode;
    int v;
    logic [16:0] exp;
    for (int i = 0; i < 1000; i++) begin
      r = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 3));
      if (mode == 0)      v = int'($urandom_range(0, 9999));
      else if (mode == 1) v = int'($urandom_range(10000, 65535));
      else                v = int'($urandom_range(0, 65535));
      exp = refConvert(v);
      runJob(r, 16'(v), a, d);
      checks++;
      if (resultNow() !== exp) $display("[TB] FAIL rand_result v=%0d: got %h want %h", v, resultNow(), exp);
      else passed++;
      checks++;
      if (int'(bus.owner) != r) $display("[TB] FAIL rand_owner v=%0d: got %b want %0d", v, bus.owner, r);
      else passed++;
      checks++;
      if (a != 1 || d != 18) $display("[TB] FAIL rand_latency v=%0d: got %0d/%0d want 1/18", v, a, d);
      else passed++;
    end
    checks++;
    if (overlapSeen != 0) $display("[TB] FAIL ack_done_overlap: got %0d want 0", overlapSeen);
    else passed++;
  endtask

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.val0 = '0;
    bus.val1 = '0;
    test_reset();
    test_single();
    test_boundary();
    test_round_robin();
    test_busy_request();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
